// File: rtl/mag_sq_arbiter.sv
// mag_sq_arbiter
// Shares one 3-stage magnitude-squared pipeline (re^2 + im^2) among four
// complex-sample requesters using a round-robin grant. Results leave in grant
// order, tagged with the originating channel. Output backpressure freezes the
// whole pipeline, bubbles included, and blocks new grants.

module mag_sq_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  output logic [3:0]           req_ready,
  input  logic [4*WIDTH-1:0]   req_real,
  input  logic [4*WIDTH-1:0]   req_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_mag,
  output logic [1:0]           out_chan,
  output logic                 busy
);

  // Round-robin pointer: the channel searched first on the next grant.
  logic [1:0]               ptr_q, ptr_d;

  // Stage 1: captured operands and channel tag.
  logic                     v1_q, v1_d;
  logic signed [WIDTH-1:0]  re1_q, re1_d;
  logic signed [WIDTH-1:0]  im1_q, im1_d;
  logic [1:0]               ch1_q, ch1_d;

  // Stage 2: the two squares, each exact in 2*WIDTH bits.
  logic                     v2_q, v2_d;
  logic [2*WIDTH-1:0]       sq_re2_q, sq_re2_d;
  logic [2*WIDTH-1:0]       sq_im2_q, sq_im2_d;
  logic [1:0]               ch2_q, ch2_d;

  // Stage 3: the sum, which drives the outputs directly.
  logic                     v3_q, v3_d;
  logic [2*WIDTH-1:0]       mag3_q, mag3_d;
  logic [1:0]               ch3_q, ch3_d;

  // Arbitration and datapath helpers.
  logic                     advance;
  logic                     grant_any;
  logic [1:0]               grant_idx;
  logic [3:0]               grant;
  logic signed [WIDTH-1:0]  sel_real;
  logic signed [WIDTH-1:0]  sel_imag;
  logic signed [2*WIDTH-1:0] re1_ext;
  logic signed [2*WIDTH-1:0] im1_ext;
  logic signed [2*WIDTH-1:0] prod_re;
  logic signed [2*WIDTH-1:0] prod_im;
  logic [2*WIDTH-1:0]       sum2;

  // The pipe moves only when the output stage is empty or being consumed.
  assign advance = !v3_q | out_ready;

  // Round-robin search starting at ptr; first requesting channel wins.
  always_comb begin
    logic [1:0] cand;
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end

  // Ready is the grant qualified by advance; forced low while in reset.
  always_comb begin
    req_ready = 4'b0000;
    if (advance && !rst) begin
      req_ready = grant;
    end
  end

  // Operand mux for the granted channel.
  always_comb begin
    sel_real = req_real[grant_idx*WIDTH +: WIDTH];
    sel_imag = req_imag[grant_idx*WIDTH +: WIDTH];
  end

  // Squares are computed at full 2*WIDTH width; the true value never exceeds
  // 2^(2W-2), so the sign bit of the product is always zero.
  always_comb begin
    re1_ext = {{WIDTH{re1_q[WIDTH-1]}}, re1_q};
    im1_ext = {{WIDTH{im1_q[WIDTH-1]}}, im1_q};
    prod_re = re1_ext * re1_ext;
    prod_im = im1_ext * im1_ext;
  end

  // Sum tops out at 2^(2W-1), which still fits unsigned in 2*WIDTH bits.
  assign sum2 = sq_re2_q + sq_im2_q;

  // Next-state for pointer and all stages; everything holds unless advancing.
  always_comb begin
    ptr_d    = ptr_q;
    v1_d     = v1_q;
    re1_d    = re1_q;
    im1_d    = im1_q;
    ch1_d    = ch1_q;
    v2_d     = v2_q;
    sq_re2_d = sq_re2_q;
    sq_im2_d = sq_im2_q;
    ch2_d    = ch2_q;
    v3_d     = v3_q;
    mag3_d   = mag3_q;
    ch3_d    = ch3_q;

    if (advance) begin
      v1_d = grant_any;
      if (grant_any) begin
        re1_d = sel_real;
        im1_d = sel_imag;
        ch1_d = grant_idx;
        ptr_d = grant_idx + 2'd1;
      end

      v2_d = v1_q;
      if (v1_q) begin
        sq_re2_d = $unsigned(prod_re);
        sq_im2_d = $unsigned(prod_im);
        ch2_d    = ch1_q;
      end

      v3_d = v2_q;
      if (v2_q) begin
        mag3_d = sum2;
        ch3_d  = ch2_q;
      end
    end
  end

  // State registers; reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= 2'd0;
      v1_q     <= 1'b0;
      re1_q    <= '0;
      im1_q    <= '0;
      ch1_q    <= 2'd0;
      v2_q     <= 1'b0;
      sq_re2_q <= '0;
      sq_im2_q <= '0;
      ch2_q    <= 2'd0;
      v3_q     <= 1'b0;
      mag3_q   <= '0;
      ch3_q    <= 2'd0;
    end else begin
      ptr_q    <= ptr_d;
      v1_q     <= v1_d;
      re1_q    <= re1_d;
      im1_q    <= im1_d;
      ch1_q    <= ch1_d;
      v2_q     <= v2_d;
      sq_re2_q <= sq_re2_d;
      sq_im2_q <= sq_im2_d;
      ch2_q    <= ch2_d;
      v3_q     <= v3_d;
      mag3_q   <= mag3_d;
      ch3_q    <= ch3_d;
    end
  end

  // Output drive straight from the last stage.
  always_comb begin
    out_valid = v3_q;
    out_mag   = mag3_q;
    out_chan  = ch3_q;
    busy      = v1_q | v2_q | v3_q;
  end

endmodule

// File: tb/tb_mag_sq_arbiter.sv
// tb_mag_sq_arbiter
// Directed bench for mag_sq_arbiter: inputs change just after the falling
// edge, outputs are sampled 1ns later, well away from the rising edge.

module tb_mag_sq_arbiter;

  localparam int WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           reqValid;
  logic [3:0]           reqReady;
  logic [4*WIDTH-1:0]   reqReal;
  logic [4*WIDTH-1:0]   reqImag;
  logic                 outValid;
  logic                 outReady;
  logic [2*WIDTH-1:0]   outMag;
  logic [1:0]           outChan;
  logic                 busy;

  int testCount = 0;
  int failCount = 0;

  mag_sq_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_real  (reqReal),
    .req_imag  (reqImag),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_mag   (outMag),
    .out_chan  (outChan),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs after the falling edge, then waits 1ns so the
  // caller can sample combinational and registered outputs.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic oRdy,
                               input logic [63:0] re, input logic [63:0] im);
    @(negedge clk);
    rst      = r;
    reqValid = v;
    outReady = oRdy;
    reqReal  = re;
    reqImag  = im;
    #1;
  endtask

  // Packs four signed components, channel 0 in the low slice.
  function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  int roundMag [4]  = '{1, 4, 9, 16};
  int bpReal   [6]  = '{1, 2, 3, 4, 5, 6};
  int bpMag    [6]  = '{2, 5, 10, 17, 26, 37};
  int bpExpOut [20] = '{-1, -1, -1, 0, 1, 1, 1, 1, 1, 1, 2, 3, 4, 5, -1, -1, -1, -1, -1, -1};
  int bubMag   [4]  = '{5, 8, 13, 20};

  initial begin
    int idx;
    logic expAcc;
    logic oRdy;
    logic expOv;

    rst      = 1'b1;
    reqValid = 4'b0000;
    outReady = 1'b1;
    reqReal  = '0;
    reqImag  = '0;

    // Reset: ready must stay low even with every requester valid.
    applyStimulus(1'b1, 4'hF, 1'b1, 64'd0, 64'd0);
    checkOutput("reset_ready0", reqReady, 0);
    applyStimulus(1'b1, 4'hF, 1'b1, 64'd0, 64'd0);
    checkOutput("reset_ready1", reqReady, 0);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_mag", outMag, 0);
    checkOutput("reset_out_chan", outChan, 0);

    // Basic: ch0 (3,4) -> 25 exactly three cycles later.
    applyStimulus(1'b0, 4'b0001, 1'b1, pack4(3, 0, 0, 0), pack4(4, 0, 0, 0));
    checkOutput("basic_ready", reqReady, 4'b0001);
    checkOutput("basic_busy_T", busy, 0);
    for (int t = 1; t <= 3; t++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
      checkOutput($sformatf("basic_busy_T%0d", t), busy, 1);
      checkOutput($sformatf("basic_valid_T%0d", t), outValid, (t == 3));
    end
    checkOutput("basic_mag", outMag, 25);
    checkOutput("basic_chan", outChan, 0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("basic_valid_after", outValid, 0);
    checkOutput("basic_busy_after", busy, 0);

    // Extremes: pointer now 1, so ch2 then ch1 are granted back to back.
    applyStimulus(1'b0, 4'b0100, 1'b1, pack4(0, 0, -32768, 0), pack4(0, 0, -32768, 0));
    checkOutput("ext_ready_ch2", reqReady, 4'b0100);
    applyStimulus(1'b0, 4'b0010, 1'b1, pack4(0, -1, 0, 0), pack4(0, 0, 0, 0));
    checkOutput("ext_ready_ch1", reqReady, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("ext_valid_early", outValid, 0);
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("ext_valid0", outValid, 1);
    checkOutput("ext_mag_max", outMag, 32'h8000_0000);
    checkOutput("ext_chan2", outChan, 2);
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("ext_valid1", outValid, 1);
    checkOutput("ext_mag_one", outMag, 1);
    checkOutput("ext_chan1", outChan, 1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("ext_valid_done", outValid, 0);

    // Round-robin fairness from ptr=0 with all four requesting.
    applyStimulus(1'b1, 4'b0000, 1'b1, 64'd0, 64'd0);
    for (int c = 0; c < 11; c++) begin
      applyStimulus(1'b0, (c < 8) ? 4'hF : 4'h0, 1'b1, pack4(1, 2, 3, 4), 64'd0);
      checkOutput($sformatf("rr_ready_c%0d", c), reqReady, (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
      if (c >= 3) begin
        checkOutput($sformatf("rr_valid_c%0d", c), outValid, 1);
        checkOutput($sformatf("rr_mag_c%0d", c), outMag, roundMag[(c - 3) % 4]);
        checkOutput($sformatf("rr_chan_c%0d", c), outChan, (c - 3) % 4);
      end
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("rr_valid_done", outValid, 0);

    // Backpressure: ch3 stream of six samples, out_ready low in cycles 4..8.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      oRdy = !(c >= 4 && c <= 8);
      applyStimulus(1'b0, (idx < 6) ? 4'b1000 : 4'b0000, oRdy,
                    pack4(0, 0, 0, bpReal[(idx < 6) ? idx : 0]), pack4(0, 0, 0, 1));
      expAcc = (idx < 6) && oRdy;
      checkOutput($sformatf("bp_ready_c%0d", c), reqReady, expAcc ? 4'b1000 : 4'b0000);
      if (expAcc) idx++;
      expOv = (bpExpOut[c] >= 0);
      checkOutput($sformatf("bp_valid_c%0d", c), outValid, expOv);
      if (expOv) begin
        checkOutput($sformatf("bp_mag_c%0d", c), outMag, bpMag[bpExpOut[c]]);
        checkOutput($sformatf("bp_chan_c%0d", c), outChan, 3);
      end
    end
    checkOutput("bp_busy_end", busy, 0);

    // Reset mid-flight: three ch0 samples in S1..S3 are discarded.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0001, 1'b1, pack4(7, 0, 0, 0), pack4(1, 0, 0, 0));
      checkOutput($sformatf("rf_ready_c%0d", c), reqReady, 4'b0001);
    end
    applyStimulus(1'b1, 4'hF, 1'b1, 64'd0, 64'd0);
    checkOutput("rf_ready_in_reset", reqReady, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
      checkOutput($sformatf("rf_valid_c%0d", c), outValid, 0);
      checkOutput($sformatf("rf_busy_c%0d", c), busy, 0);
    end
    applyStimulus(1'b0, 4'hF, 1'b1, pack4(5, 6, 7, 8), pack4(12, 0, 0, 0));
    checkOutput("rf_first_grant", reqReady, 4'b0001);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
      checkOutput($sformatf("rf_post_valid_c%0d", c), outValid, 0);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, 64'd0, 64'd0);
    checkOutput("rf_post_valid", outValid, 1);
    checkOutput("rf_post_mag", outMag, 169);
    checkOutput("rf_post_chan", outChan, 0);

    // Idle bubbles: ch1 every other cycle, pointer must wrap back to it.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, ((c % 2 == 0) && (c < 8)) ? 4'b0010 : 4'b0000, 1'b1,
                    pack4(0, c / 2 + 1, 0, 0), pack4(0, 2, 0, 0));
      checkOutput($sformatf("bub_ready_c%0d", c), reqReady,
                  ((c % 2 == 0) && (c < 8)) ? 4'b0010 : 4'b0000);
      expOv = (c >= 3) && ((c - 3) % 2 == 0) && ((c - 3) < 8);
      checkOutput($sformatf("bub_valid_c%0d", c), outValid, expOv);
      if (expOv) begin
        checkOutput($sformatf("bub_mag_c%0d", c), outMag, bubMag[(c - 3) / 2]);
        checkOutput($sformatf("bub_chan_c%0d", c), outChan, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mag_sq_arbiter.md
# mag_sq_arbiter

Round-robin scheduler that shares one pipelined magnitude-squared unit (re² + im²) among four complex-sample requesters in the dotProduct datapath. Each requester offers a signed complex sample with a valid/ready handshake. The block grants one sample per cycle, pushes it through a 3-stage multiply-add pipeline, and returns the unsigned result tagged with the originating channel. Backpressure on the output stalls the whole pipeline and blocks new grants.

## Interface
- WIDTH, 16, bit width of each signed real/imag component
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  bit i: requester i offers a sample
- req_ready  output  4  bit i: sample i accepted this cycle (one-hot or zero)
- req_real  input  4*WIDTH  signed real parts; channel i at [i*WIDTH +: WIDTH]
- req_imag  input  4*WIDTH  signed imag parts; same packing
- out_valid  output  1  out_mag/out_chan hold a result
- out_ready  input  1  downstream accepts the result
- out_mag  output  2*WIDTH  unsigned re² + im²
- out_chan  output  2  channel index of the result
- busy  output  1  any pipeline stage holds a valid entry

## Operation
- Pipeline stages:
  - S1: registered operands and channel tag.
  - S2: registered products re², im², each 2*WIDTH unsigned.
  - S3: registered sum, which drives the outputs.
- Each stage has a valid bit.
- advance = !out_valid | out_ready. All stages load only when advance=1. When advance=0, every stage holds, including bubbles.
- Arbitration:
  - Round-robin pointer ptr (2 bits).
  - Grant goes to the first i in order ptr, ptr+1, … (mod 4) with req_valid[i]=1.
  - req_ready[i] = advance & grant[i]. It is combinational from req_valid, so requesters must not make valid depend on ready.
- On a grant to i: ptr ← (i+1) mod 4. With no grant or advance=0, ptr holds.
- Arithmetic:
  - Inputs are two's complement.
  - Each square is exact in 2*WIDTH bits; the maximum is 2^(2W−2).
  - The sum is at most 2^(2W−1), so it fits in 2*WIDTH unsigned with no truncation or saturation.
- busy = v1 | v2 | v3.
- Reset values:
  - All valid bits, ptr, out_mag, out_chan and busy are 0.
  - req_ready is 0 during reset, independent of req_valid.

## Timing
- Latency: a sample accepted in cycle T (req_valid[i] & req_ready[i]) appears with out_valid=1 in cycle T+3 when no stall occurs.
- Throughput: 1 result per cycle when out_ready is held at 1.
- Stall: while out_valid=1 and out_ready=0:
  - out_mag and out_chan are stable.
  - req_ready is 0.
  - No stage changes.
  - The stall releases in the cycle out_ready rises; the result is consumed and everything shifts on that edge.
- Empty pipe: out_valid=0 implies advance=1, so grants continue regardless of out_ready.
- Results leave in grant order. No reordering and no drops.
- Simultaneous requests: with all four valid from ptr=0, grants go 0,1,2,3,0,… on consecutive cycles.
- Single persistent requester: granted every cycle. The pointer moves past it but wraps back to it.
- Reset asserted mid-operation: all in-flight results are discarded on that edge. out_valid=0 and ptr=0 the next cycle; no partial result emerges.

## Test plan
- Basic: reset, then ch0 real=3, imag=4 for one cycle with out_ready=1. Required: req_ready=0001 that cycle; out_valid=1, out_mag=25, out_chan=0 exactly 3 cycles later; busy high for cycles T+1..T+3.
- Extremes (WIDTH=16): ch2 real=imag=−32768 → out_mag=0x8000_0000. ch1 real=−1, imag=0 → out_mag=1.
- Round-robin fairness: all four req_valid held high, operands (i+1, 0) for channel i, for 8 cycles. Required: grants in order 0,1,2,3,0,1,2,3; outputs 1,4,9,16,1,4,9,16 with matching out_chan.
- Backpressure: stream into ch3; drop out_ready for 5 cycles while out_valid=1. Required: output frozen, req_ready=0000, no loss or duplication after out_ready returns; results still in order.
- Reset mid-flight: issue 3 samples, assert rst for 1 cycle while they are in S1..S3. Required: out_valid=0 and busy=0 after reset, none of the 3 results appear, and the next grant starts at ch0.
- Idle bubbles: ch1 valid every other cycle. Required: a result every other cycle, out_valid=0 in the gaps, ptr wrap does not starve ch1.
